// File: rtl/dense_pkg.sv
// dense_pkg: shared types and helpers for the dense layer engine.
//   state_t   : engine sequencing states (also exported for debug/observation)
//   DEF_*     : default Q-format (Q15.16 in a 32-bit word)
//   sat_shift : accumulator -> result word, arithmetic shift by the fractional
//               width followed by signed saturation to the data width.
package dense_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BIAS   = 3'd1,
        MAC    = 3'd2,
        ACT    = 3'd3,
        ARGMAX = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 16;

    // Working widths for sat_shift; callers sign-extend into / truncate out of
    // these, so any ACC_W <= 128 and DATA_W <= 64 is supported.
    localparam int SAT_ACC_W  = 128;
    localparam int SAT_DATA_W = 64;

    function automatic logic signed [SAT_DATA_W-1:0] sat_shift(
        input logic signed [SAT_ACC_W-1:0] acc,
        input int                          frac_w,
        input int                          data_w
    );
        logic signed [SAT_ACC_W-1:0] r;
        logic signed [SAT_ACC_W-1:0] hi;
        logic signed [SAT_ACC_W-1:0] lo;
        r  = acc >>> frac_w;
        hi = 128'sd1 <<< (data_w - 1);
        lo = -hi;
        hi = hi - 128'sd1;
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return SAT_DATA_W'(r);
    endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// dense_mac_lane: one neuron of the dense layer.
//   load_bias : acc <= sign-extended b_data << FRAC_W
//   acc_en    : acc <= acc + in_data * w_data (full-precision signed product)
//   act_en    : result <= ReLU(saturate(acc >>> FRAC_W))
//   result    : registered lane output, held until the next act_en
module dense_mac_lane
    import dense_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int ACC_W   = 64,
    parameter int RELU_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_bias,
    input  logic                     acc_en,
    input  logic                     act_en,
    input  logic signed [DATA_W-1:0] b_data,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic signed [DATA_W-1:0] w_data,
    output logic signed [DATA_W-1:0] result
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [DATA_W-1:0]   act_val;

    assign prod     = in_data * w_data;
    assign bias_ext = ACC_W'(b_data) <<< FRAC_W;

    always_comb begin
        act_val = DATA_W'(sat_shift(SAT_ACC_W'(acc), FRAC_W, DATA_W));
        if (RELU_EN != 0 && act_val < 0) begin
            act_val = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (load_bias) begin
                acc <= bias_ext;
            end else if (acc_en) begin
                acc <= acc + ACC_W'(prod);
            end
            if (act_en) begin
                result <= act_val;
            end
        end
    end

endmodule

// File: rtl/dense_layer_engine.sv
// dense_layer_engine: N_OUT-lane fully-connected layer with sequential argmax.
//   start/busy          : pass control; start only sampled in IDLE
//   in_addr/in_rd       : shared input+weight memory read port (1-cycle latency)
//   in_data/w_data      : activation and packed per-lane weights
//   b_addr/b_rd/b_data  : bias memory read port (1-cycle latency)
//   out_valid/out_ready : result handshake
//   out_vec/out_argmax  : packed lane results and index of the largest one
//   dbg_state           : current sequencing state
//
// Result handshake: out_valid rises once the vector and argmax are final and
// stays high, with out_vec/out_argmax frozen, until a cycle where out_ready
// is also high; that edge completes the transfer, returns to IDLE and drops
// out_valid. out_valid never depends combinationally on out_ready.
module dense_layer_engine
    import dense_pkg::*;
#(
    parameter int N_IN    = 784,
    parameter int N_OUT   = 10,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int ACC_W   = 64,
    parameter int RELU_EN = 1,
    localparam int AW     = (N_IN  > 1) ? $clog2(N_IN)  : 1,
    localparam int LW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic [AW-1:0]           in_addr,
    output logic                    in_rd,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [N_OUT*DATA_W-1:0] w_data,
    output logic [LW-1:0]           b_addr,
    output logic                    b_rd,
    input  logic [DATA_W-1:0]       b_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_OUT*DATA_W-1:0] out_vec,
    output logic [LW-1:0]           out_argmax,
    output state_t                  dbg_state
);

    localparam int MAXC  = (N_IN > N_OUT) ? N_IN : N_OUT;
    localparam int CNT_W = $clog2(MAXC + 2);

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_nxt;
    logic                     b_rd_q;
    logic [LW-1:0]            b_idx_q;
    logic                     in_rd_q;
    logic signed [DATA_W-1:0] max_val;
    logic [LW-1:0]            max_idx;
    logic [LW-1:0]            lane_sel;
    logic signed [DATA_W-1:0] cur;
    logic signed [DATA_W-1:0] lane_res [N_OUT];

    assign cnt_nxt   = cnt + 1'b1;
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign lane_sel  = LW'(cnt);
    assign cur       = lane_res[lane_sel];

    for (genvar j = 0; j < N_OUT; j++) begin : g_lane
        dense_mac_lane #(
            .DATA_W (DATA_W),
            .FRAC_W (FRAC_W),
            .ACC_W  (ACC_W),
            .RELU_EN(RELU_EN)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load_bias(b_rd_q && (b_idx_q == LW'(j))),
            .acc_en   (in_rd_q),
            .act_en   (state == ACT),
            .b_data   (b_data),
            .in_data  (in_data),
            .w_data   (w_data[j*DATA_W +: DATA_W]),
            .result   (lane_res[j])
        );
        assign out_vec[j*DATA_W +: DATA_W] = lane_res[j];
    end

    // Read strobes delayed by the memory latency: they mark the cycle in
    // which b_data / in_data+w_data are valid for the lanes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rd_q  <= 1'b0;
            b_idx_q <= '0;
            in_rd_q <= 1'b0;
        end else begin
            b_rd_q  <= b_rd;
            b_idx_q <= b_addr;
            in_rd_q <= in_rd;
        end
    end

    // Sequencer. Strobes and addresses are registered, so each is set on the
    // edge that enters the cycle in which it must be visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            in_rd      <= 1'b0;
            in_addr    <= '0;
            b_rd       <= 1'b0;
            b_addr     <= '0;
            out_valid  <= 1'b0;
            out_argmax <= '0;
            max_val    <= '0;
            max_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= BIAS;
                        cnt    <= '0;
                        b_rd   <= 1'b1;
                        b_addr <= '0;
                    end
                end
                BIAS: begin
                    if (cnt == CNT_W'(N_OUT)) begin
                        state   <= MAC;
                        cnt     <= '0;
                        in_rd   <= 1'b1;
                        in_addr <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt < CNT_W'(N_OUT)) begin
                            b_rd   <= 1'b1;
                            b_addr <= LW'(cnt_nxt);
                        end else begin
                            b_rd   <= 1'b0;
                            b_addr <= '0;
                        end
                    end
                end
                MAC: begin
                    if (cnt == CNT_W'(N_IN)) begin
                        state <= ACT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                        if (cnt_nxt < CNT_W'(N_IN)) begin
                            in_rd   <= 1'b1;
                            in_addr <= AW'(cnt_nxt);
                        end else begin
                            in_rd   <= 1'b0;
                            in_addr <= '0;
                        end
                    end
                end
                ACT: begin
                    state <= ARGMAX;
                    cnt   <= '0;
                end
                ARGMAX: begin
                    // Strict '>' keeps the lowest index on ties.
                    if (cnt == '0 || cur > max_val) begin
                        max_val <= cur;
                        max_idx <= lane_sel;
                    end
                    if (cnt == CNT_W'(N_OUT - 1)) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                DONE: begin
                    // First DONE cycle commits the argmax and raises out_valid.
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        out_argmax <= max_idx;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_engine.sv
module tb_dense_layer_engine;
    import dense_pkg::*;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int DW    = 16;
    localparam int FW    = 8;
    localparam int ACCW  = 40;
    localparam int AW    = 2;
    localparam int LW    = 1;
    localparam int LAT   = 2*N_OUT + N_IN + 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    always #5 clk = ~clk;

    // DUT r: RELU_EN=1, DUT p: RELU_EN=0
    logic busy_r, in_rd_r, b_rd_r, out_valid_r;
    logic [AW-1:0] in_addr_r;
    logic [LW-1:0] b_addr_r, out_argmax_r;
    logic [DW-1:0] in_data_r, b_data_r;
    logic [N_OUT*DW-1:0] w_data_r, out_vec_r;
    state_t state_r;

    logic busy_p, in_rd_p, b_rd_p, out_valid_p;
    logic [AW-1:0] in_addr_p;
    logic [LW-1:0] b_addr_p, out_argmax_p;
    logic [DW-1:0] in_data_p, b_data_p;
    logic [N_OUT*DW-1:0] w_data_p, out_vec_p;
    state_t state_p;

    dense_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .FRAC_W(FW),
                         .ACC_W(ACCW), .RELU_EN(1)) dut_r (
        .clk(clk), .rst(rst), .start(start), .busy(busy_r),
        .in_addr(in_addr_r), .in_rd(in_rd_r), .in_data(in_data_r), .w_data(w_data_r),
        .b_addr(b_addr_r), .b_rd(b_rd_r), .b_data(b_data_r),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_vec(out_vec_r),
        .out_argmax(out_argmax_r), .dbg_state(state_r));

    dense_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .FRAC_W(FW),
                         .ACC_W(ACCW), .RELU_EN(0)) dut_p (
        .clk(clk), .rst(rst), .start(start), .busy(busy_p),
        .in_addr(in_addr_p), .in_rd(in_rd_p), .in_data(in_data_p), .w_data(w_data_p),
        .b_addr(b_addr_p), .b_rd(b_rd_p), .b_data(b_data_p),
        .out_valid(out_valid_p), .out_ready(out_ready), .out_vec(out_vec_p),
        .out_argmax(out_argmax_p), .dbg_state(state_p));

    // ---------------- memories (1-cycle read latency) ----------------
    int in_mem [N_IN];
    int w_mem  [N_IN][N_OUT];
    int b_mem  [N_OUT];

    always @(posedge clk) begin
        if (in_rd_r) begin
            in_data_r <= 16'(in_mem[in_addr_r]);
            for (int j = 0; j < N_OUT; j++) w_data_r[j*DW +: DW] <= 16'(w_mem[in_addr_r][j]);
        end
        if (b_rd_r) b_data_r <= 16'(b_mem[b_addr_r]);
    end

    always @(posedge clk) begin
        if (in_rd_p) begin
            in_data_p <= 16'(in_mem[in_addr_p]);
            for (int j = 0; j < N_OUT; j++) w_data_p[j*DW +: DW] <= 16'(w_mem[in_addr_p][j]);
        end
        if (b_rd_p) b_data_p <= 16'(b_mem[b_addr_p]);
    end

    // ---------------- reference model ----------------
    longint exp_r [N_OUT];
    longint exp_p [N_OUT];
    int     exp_am_r, exp_am_p;

    task automatic compute_expected();
        for (int j = 0; j < N_OUT; j++) begin
            longint acc, r;
            acc = longint'(b_mem[j]) * (longint'(1) << FW);
            for (int i = 0; i < N_IN; i++) acc += longint'(in_mem[i]) * longint'(w_mem[i][j]);
            r = acc >>> FW;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            exp_p[j] = r;
            exp_r[j] = (r < 0) ? 0 : r;
        end
        exp_am_r = 0;
        exp_am_p = 0;
        for (int j = 1; j < N_OUT; j++) begin
            if (exp_r[j] > exp_r[exp_am_r]) exp_am_r = j;
            if (exp_p[j] > exp_p[exp_am_p]) exp_am_p = j;
        end
    endtask

    task automatic set_uniform(input int iv, input int w0, input int w1, input int b0, input int b1);
        for (int i = 0; i < N_IN; i++) begin
            in_mem[i]   = iv;
            w_mem[i][0] = w0;
            w_mem[i][1] = w1;
        end
        b_mem[0] = b0;
        b_mem[1] = b1;
    endtask

    function automatic int rnd_val(input bit wide);
        logic signed [15:0] t;
        if (wide) begin
            t = 16'($urandom());
            return int'(t);
        end
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_results(input string tag);
        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("%s_r_lane%0d", tag, j), $signed(out_vec_r[j*DW +: DW]), exp_r[j]);
            check($sformatf("%s_p_lane%0d", tag, j), $signed(out_vec_p[j*DW +: DW]), exp_p[j]);
        end
        check({tag, "_r_argmax"}, {1'b0, out_argmax_r}, exp_am_r);
        check({tag, "_p_argmax"}, {1'b0, out_argmax_p}, exp_am_p);
    endtask

    // per-cycle trace of the read ports, index 0 = cycle after start is sampled
    logic          tr_brd    [2][128];
    logic [LW-1:0] tr_baddr  [2][128];
    logic          tr_inrd   [2][128];
    logic [AW-1:0] tr_inaddr [2][128];
    logic          tr_busy   [2][128];

    // ---------------- driver tasks ----------------
    task automatic run_pass(input string tag, input bit trace_check);
        int cyc;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (out_valid_r !== 1'b1 && cyc < 100) begin
            tr_brd[0][cyc] = b_rd_r;   tr_baddr[0][cyc] = b_addr_r;
            tr_inrd[0][cyc] = in_rd_r; tr_inaddr[0][cyc] = in_addr_r; tr_busy[0][cyc] = busy_r;
            tr_brd[1][cyc] = b_rd_p;   tr_baddr[1][cyc] = b_addr_p;
            tr_inrd[1][cyc] = in_rd_p; tr_inaddr[1][cyc] = in_addr_p; tr_busy[1][cyc] = busy_p;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_p_valid"}, {1'b0, out_valid_p}, 1);
        if (trace_check) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < cyc && c < LAT; c++) begin
                    bit eb, ei;
                    eb = (c < N_OUT);
                    ei = (c >= N_OUT + 1) && (c < N_OUT + 1 + N_IN);
                    check($sformatf("%s_d%0d_c%0d_b_rd", tag, d, c), {1'b0, tr_brd[d][c]}, eb);
                    check($sformatf("%s_d%0d_c%0d_b_addr", tag, d, c), {1'b0, tr_baddr[d][c]}, eb ? c : 0);
                    check($sformatf("%s_d%0d_c%0d_in_rd", tag, d, c), {1'b0, tr_inrd[d][c]}, ei);
                    check($sformatf("%s_d%0d_c%0d_in_addr", tag, d, c), {1'b0, tr_inaddr[d][c]},
                          ei ? c - (N_OUT + 1) : 0);
                    check($sformatf("%s_d%0d_c%0d_busy", tag, d, c), {1'b0, tr_busy[d][c]}, 1);
                end
            end
        end
        check_results(tag);
    endtask

    task automatic accept(input string tag);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_acc_r_valid"}, {1'b0, out_valid_r}, 0);
        check({tag, "_acc_r_busy"}, {1'b0, busy_r}, 0);
        check({tag, "_acc_p_valid"}, {1'b0, out_valid_p}, 0);
        check({tag, "_acc_p_busy"}, {1'b0, busy_p}, 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, {1'b0, busy_r}, 0);
        check({tag, "_valid"}, {1'b0, out_valid_r}, 0);
        check({tag, "_in_rd"}, {1'b0, in_rd_r}, 0);
        check({tag, "_b_rd"}, {1'b0, b_rd_r}, 0);
        check({tag, "_in_addr"}, {1'b0, in_addr_r}, 0);
        check({tag, "_b_addr"}, {1'b0, b_addr_r}, 0);
        check({tag, "_vec"}, {1'b0, out_vec_r}, 0);
        check({tag, "_argmax"}, {1'b0, out_argmax_r}, 0);
        check({tag, "_p_vec"}, {1'b0, out_vec_p}, 0);
        check({tag, "_p_busy"}, {1'b0, busy_p}, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        set_uniform(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // basic case, with read-port schedule check
        set_uniform(256, 128, -64, 256, 128);
        compute_expected();
        run_pass("basic", 1'b1);
        check("basic_lane0_abs", $signed(out_vec_r[0 +: DW]), 768);
        check("basic_lane1_relu_abs", $signed(out_vec_r[DW +: DW]), 0);
        check("basic_lane1_raw_abs", $signed(out_vec_p[DW +: DW]), -128);
        accept("basic");

        // positive saturation
        set_uniform(32767, 32767, 32767, 0, 0);
        compute_expected();
        run_pass("satpos", 1'b0);
        check("satpos_abs", $signed(out_vec_p[0 +: DW]), 32767);
        accept("satpos");

        // negative saturation
        set_uniform(32767, -32768, -32768, 0, 0);
        compute_expected();
        run_pass("satneg", 1'b0);
        check("satneg_abs", $signed(out_vec_p[DW +: DW]), -32768);
        accept("satneg");

        // ties resolve to the lowest index
        set_uniform(256, 128, 128, 0, 0);
        compute_expected();
        run_pass("tie", 1'b0);
        check("tie_argmax_abs", {1'b0, out_argmax_r}, 0);
        accept("tie");
        set_uniform(256, 128, 128, 0, 1);
        compute_expected();
        run_pass("untie", 1'b0);
        check("untie_lane1_abs", $signed(out_vec_r[DW +: DW]), 513);
        check("untie_argmax_abs", {1'b0, out_argmax_r}, 1);
        accept("untie");

        // backpressure in DONE; start pulses there are ignored
        set_uniform(256, 128, -64, 256, 128);
        compute_expected();
        run_pass("bp", 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) start = 1'b1;
            if (k == 3) start = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_valid", k), {1'b0, out_valid_r}, 1);
            check_results($sformatf("bp_hold%0d", k));
        end
        start = 1'b0;
        accept("bp");
        repeat (3) begin
            @(posedge clk);
            #1 check("bp_stays_idle", {1'b0, busy_r}, 0);
        end

        // reset in MAC cycle 2
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (N_OUT + 1 + 2) begin
            @(posedge clk);
            #1;
        end
        check("rst_at_mac", {1'b0, state_r}, {1'b0, MAC});
        rst = 1'b1;
        #1 check_idle_zero("midrst");
        @(negedge clk) rst = 1'b0;
        run_pass("after_rst", 1'b0);
        accept("after_rst");

        // randomized passes
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < N_IN; i++) begin
                in_mem[i] = rnd_val(n[0]);
                for (int j = 0; j < N_OUT; j++) w_mem[i][j] = rnd_val(n[0]);
            end
            for (int j = 0; j < N_OUT; j++) b_mem[j] = rnd_val(n[1]);
            compute_expected();
            run_pass($sformatf("rnd%0d", n), 1'b0);
            accept($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
